// File: rtl/secure_frame_scheduler_pkg.sv
// Shared types and constants for the secure UART frame scheduler.
// Frames are SYNC, SEQ, CIPHER, CHECKSUM, PARITY.
package secure_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_DRAIN
  } sfs_state_e;

  localparam int unsigned FRAME_LEN = 5;

  localparam logic [2:0] IDX_SYNC   = 3'd0;
  localparam logic [2:0] IDX_SEQ    = 3'd1;
  localparam logic [2:0] IDX_CIPHER = 3'd2;
  localparam logic [2:0] IDX_CSUM   = 3'd3;
  localparam logic [2:0] IDX_PAR    = 3'd4;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;

  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic [7:0] sync,
    input logic [7:0] sq,
    input logic [7:0] cip,
    input logic [7:0] chk
  );
    logic [7:0] b;
    b = sync;
    unique case (idx)
      IDX_SYNC:   b = sync;
      IDX_SEQ:    b = sq;
      IDX_CIPHER: b = cip;
      IDX_CSUM:   b = chk;
      IDX_PAR:    b = sq ^ cip ^ chk;
      default:    b = sync;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/secure_frame_scheduler_if.sv
// Sample input, UART handshake and status bundle
// of the secure frame scheduler.
interface secure_frame_scheduler_if;
  import secure_link_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] cipher;
  logic [7:0] checksum;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_done;
  logic [7:0] seq;
  logic [7:0] drop_cnt;
  logic [7:0] retry_cnt;

  modport slave (
    input  in_valid, cipher, checksum, tx_busy,
    output in_ready, tx_data, tx_start,
    output frame_done, seq, drop_cnt, retry_cnt
  );

  modport master (
    output in_valid, cipher, checksum, tx_busy,
    input  in_ready, tx_data, tx_start,
    input  frame_done, seq, drop_cnt, retry_cnt
  );

endinterface

// File: rtl/secure_frame_scheduler_slot.sv
// Single-entry sample holding slot with overflow
// drop counting.
module sample_hold_slot
  import secure_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  logic [7:0] cipher_i,
  input  logic [7:0] checksum_i,
  input  logic       load_i,
  output logic       in_ready_o,
  output logic       hold_valid_o,
  output logic [7:0] cipher_o,
  output logic [7:0] checksum_o,
  output logic [7:0] drop_cnt_o
);

  logic       hold_q, hold_d;
  logic [7:0] cip_q, cip_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] drop_q, drop_d;
  logic       accept;
  logic       drop;

  // Emptying the slot this cycle frees it for a same-cycle arrival.
  assign in_ready_o = !hold_q | load_i;
  assign accept = in_valid_i & in_ready_o;
  assign drop   = in_valid_i & !in_ready_o;

  always_comb begin
    hold_d = hold_q;
    cip_d  = cip_q;
    chk_d  = chk_q;
    drop_d = drop_q;
    if (load_i) hold_d = 1'b0;
    if (accept) begin
      hold_d = 1'b1;
      cip_d  = cipher_i;
      chk_d  = checksum_i;
    end
    if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      cip_q  <= '0;
      chk_q  <= '0;
      drop_q <= '0;
    end else begin
      hold_q <= hold_d;
      cip_q  <= cip_d;
      chk_q  <= chk_d;
      drop_q <= drop_d;
    end
  end

  assign hold_valid_o = hold_q;
  assign cipher_o     = cip_q;
  assign checksum_o   = chk_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: rtl/secure_frame_scheduler.sv
// Frames held samples into 5-byte UART frames with
// start/busy handshake, busy timeout and retry.
module secure_frame_scheduler
  import secure_link_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int unsigned BUSY_WAIT = 16
) (
  input logic clk,
  input logic rst_n,
  secure_frame_scheduler_if.slave bus
);

  localparam logic [15:0] TMAX = 16'(BUSY_WAIT - 1);

  sfs_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  fseq_q, fseq_d;
  logic [7:0]  fcip_q, fcip_d;
  logic [7:0]  fchk_q, fchk_d;
  logic [7:0]  txd_q, txd_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  retry_q, retry_d;
  logic        tx_start;
  logic        frame_done;
  logic        load;
  logic        hold_valid;
  logic [7:0]  hold_cip;
  logic [7:0]  hold_chk;
  logic [7:0]  drop_cnt;
  logic        in_ready;
  logic [2:0]  idx_nx;

  assign load   = (state_q == S_IDLE) & hold_valid;
  assign idx_nx = idx_q + 3'd1;

  sample_hold_slot u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (bus.in_valid),
    .cipher_i     (bus.cipher),
    .checksum_i   (bus.checksum),
    .load_i       (load),
    .in_ready_o   (in_ready),
    .hold_valid_o (hold_valid),
    .cipher_o     (hold_cip),
    .checksum_o   (hold_chk),
    .drop_cnt_o   (drop_cnt)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    fseq_d     = fseq_q;
    fcip_d     = fcip_q;
    fchk_d     = fchk_q;
    txd_d      = txd_q;
    seq_d      = seq_q;
    retry_d    = retry_q;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_ISSUE;
          idx_d   = IDX_SYNC;
          fseq_d  = seq_q;
          fcip_d  = hold_cip;
          fchk_d  = hold_chk;
          txd_d   = SYNC_BYTE;
        end
      end
      S_ISSUE: begin
        if (!bus.tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_ACK;
          timer_d  = '0;
        end
      end
      S_ACK: begin
        if (bus.tx_busy) begin
          state_d = S_DRAIN;
        end else if (timer_q + 16'd1 == TMAX) begin
          state_d = S_ISSUE;
          if (retry_q != 8'hFF)
            retry_d = retry_q + 8'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (!bus.tx_busy) begin
          if (idx_q == IDX_PAR) begin
            frame_done = 1'b1;
            seq_d      = seq_q + 8'd1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_nx;
            txd_d   = frame_byte(idx_nx, SYNC_BYTE,
                                 fseq_q, fcip_q, fchk_q);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      fseq_q  <= '0;
      fcip_q  <= '0;
      fchk_q  <= '0;
      txd_q   <= '0;
      seq_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      fseq_q  <= fseq_d;
      fcip_q  <= fcip_d;
      fchk_q  <= fchk_d;
      txd_q   <= txd_d;
      seq_q   <= seq_d;
      retry_q <= retry_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.tx_data    = txd_q;
  assign bus.tx_start   = tx_start;
  assign bus.frame_done = frame_done;
  assign bus.seq        = seq_q;
  assign bus.drop_cnt   = drop_cnt;
  assign bus.retry_cnt  = retry_q;

endmodule

// File: doc/secure_frame_scheduler.md
# secure_frame_scheduler

Sequences encrypted ultrasonic samples onto the shared UART transmitter as fixed 5-byte frames. It sits between `spn_encryptor` and `uart_tx_top` and replaces ad-hoc byte phasing with a defined protocol:
- holds one pending sample;
- frames it with sync, sequence and parity bytes;
- drives the UART start/busy handshake with timeout-and-retry.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hAA, first byte of every frame
- `BUSY_WAIT`, 16, cycles allowed for `tx_busy` to rise after `tx_start` before re-issuing (≥2)

Ports:
- `clk`  in  1  system clock (100 MHz); single clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  encrypted sample present (one-cycle pulse from encryptor)
- `in_ready`  out  1  sample holding slot free, or being emptied this cycle
- `cipher`  in  8  encrypted distance byte
- `checksum`  in  8  encryptor checksum byte
- `tx_data`  out  8  byte to UART; stable from ISSUE until the byte completes
- `tx_start`  out  1  one-cycle UART start request
- `tx_busy`  in  1  UART transmitting
- `frame_done`  out  1  one-cycle pulse when the last byte's `tx_busy` falls
- `seq`  out  8  sequence number of the next frame to send
- `drop_cnt`  out  8  samples lost because the slot was full; saturating
- `retry_cnt`  out  8  start re-issues due to timeout; saturating

## Operation
- **Holding slot:** one entry (`hold_valid`, cipher, checksum).
  - `load` = (state==IDLE) & `hold_valid`.
  - `in_ready` = !`hold_valid` | `load`.
  - `in_valid` & `in_ready`: capture the sample and set `hold_valid`.
  - `in_valid` & !`in_ready`: discard the sample; `drop_cnt`++ (saturates at 255).
- **Frame:** byte0 `SYNC_BYTE`, byte1 `seq`, byte2 cipher, byte3 checksum, byte4 = byte1^byte2^byte3.
  - On `load`, bytes 1–3 are copied into the frame registers and `hold_valid` clears.
  - The slot can therefore refill while a frame is in flight.
- **FSM states:** IDLE, ISSUE, ACK, DRAIN.
  - **IDLE:** on `load` → ISSUE; `idx`=0.
  - **ISSUE:** if `tx_busy`=0, assert `tx_start` for this cycle → ACK, timer=0; otherwise stay in ISSUE.
  - **ACK:**
    - `tx_busy`=1 → DRAIN.
    - If the timer reaches `BUSY_WAIT`-1 without `tx_busy`: `retry_cnt`++ (saturating) → ISSUE, same `idx`.
  - **DRAIN:** on `tx_busy`=0:
    - if `idx`==4: pulse `frame_done`, `seq`++ (wraps FF→00), → IDLE;
    - else `idx`++ → ISSUE.
- `tx_data` = frame byte[`idx`], registered. It never changes outside the IDLE→ISSUE and DRAIN→ISSUE transitions.

## Timing
- **Reset values:**
  - `tx_start`, `frame_done`: 0.
  - `tx_data`: 00.
  - `seq`, `drop_cnt`, `retry_cnt`: 0.
  - `in_ready`: 1.
  - state: IDLE; `hold_valid`: 0.
- **Latency:** with the block IDLE and the slot empty, `in_valid` at cycle 0 → `hold_valid` at cycle 1 → `tx_start`=1 at cycle 2 with `tx_data`=`SYNC_BYTE`.
- `tx_start` is high for exactly one cycle per issue attempt. It is never asserted while `tx_busy`=1.
- **Same-cycle load and arrival:** `in_valid` in the same cycle as `load` is accepted with no drop.
- **Busy already high at ACK entry:** `tx_busy` high in the first ACK cycle moves to DRAIN on the next edge.
- **Mid-operation reset:** `rst_n` low mid-frame immediately clears all state and outputs. The partial frame is abandoned, not resumed.
- **Minimum spacing:** one idle cycle (IDLE) occurs between consecutive frames.

## Structure
- **Package `secure_link_pkg`:**
  - FSM state enum;
  - `FRAME_LEN`=5;
  - byte index constants (`IDX_SYNC`..`IDX_PAR`);
  - default `SYNC_BYTE`.
- **Sub-module `sample_hold_slot`:** the single-entry holding register with the `in_ready`, load and drop logic, and `drop_cnt`.
- The top level instantiates it together with the FSM, timer and frame registers.

## Test plan
- **Single frame:** cipher 3C, checksum 5A, UART model with `tx_busy` rising 1 cycle after start and lasting 10 cycles → bytes AA,00,3C,5A,66 in order. Expect one `frame_done`, `seq`=1, `tx_start` at cycle 2.
- **Back-to-back samples:** two samples 2 cycles apart (11/22, then 33/44) → second frame AA,01,33,44,76 follows with no drop. `drop_cnt`=0.
- **Overflow:** three samples during one frame → third dropped. `drop_cnt`=1; second frame sent intact.
- **Lost start:** UART ignores the first start, `BUSY_WAIT`=16 → `tx_start` re-pulsed 16 cycles later with the same `tx_data`=AA. `retry_cnt`=1; frame completes.
- **Reset mid-frame:** `rst_n` low during byte 2 → `tx_start` 0 and `seq` 0 immediately. The next sample produces a frame beginning AA,00.
- **Saturation and wrap:** 300 drops → `drop_cnt` holds at FF. After 256 frames, `seq` wraps to 00.
